// File: rtl/bip_mem_responder_if.sv
// CPU ROM/RAM request bus plus IMEM load stream between the BIP CPU/loader and bip_mem_responder.
// master = CPU/loader side, slave = memory responder side.
interface bip_mem_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] rom_addr_i;
    logic              enrom_i;
    logic [DATA_W-1:0] rom_data_o;
    logic [ADDR_W-1:0] ram_addr_i;
    logic              enram_i;
    logic              wrram_i;
    logic [DATA_W-1:0] ram_data_i;
    logic [DATA_W-1:0] ram_data_o;
    logic              load_valid_i;
    logic [DATA_W-1:0] load_data_i;
    logic              load_last_i;
    logic              load_ready_o;

    modport master (
        output rom_addr_i, enrom_i, ram_addr_i, enram_i, wrram_i, ram_data_i,
               load_valid_i, load_data_i, load_last_i,
        input  rom_data_o, ram_data_o, load_ready_o
    );

    modport slave (
        input  rom_addr_i, enrom_i, ram_addr_i, enram_i, wrram_i, ram_data_i,
               load_valid_i, load_data_i, load_last_i,
        output rom_data_o, ram_data_o, load_ready_o
    );
endinterface

// File: rtl/bip_mem_responder.sv
// BIP memory responder: IMEM filled from a load stream in LOAD, then 1-cycle ROM/RAM reads in RUN.
// Optional feature macro BIP_MEM_IO_EN maps a GPIO output register at IO_ADDR.
module bip_mem_responder #(
    parameter int              ADDR_W     = 11,
    parameter int              DATA_W     = 16,
    parameter int              IMEM_DEPTH = 2048,
    parameter int              DMEM_DEPTH = 2048,
    parameter logic [ADDR_W-1:0] IO_ADDR  = {ADDR_W{1'b1}}
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bip_mem_responder_if.slave bus,
    output logic               run_o,
    output logic [DATA_W-1:0]  gpio_o
);
    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state;
    logic [IA_W-1:0]   load_ptr;
    logic [DATA_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [IA_W-1:0]   rom_idx;
    logic [DA_W-1:0]   ram_idx;
    logic              load_beat;
    logic              in_run;
    logic              io_hit;
    logic              dmem_we;

    assign rom_idx   = bus.rom_addr_i[IA_W-1:0];
    assign ram_idx   = bus.ram_addr_i[DA_W-1:0];
    assign load_beat = (state == ST_LOAD) && bus.load_valid_i && bus.load_ready_o;
    assign in_run    = (state == ST_RUN);

`ifdef BIP_MEM_IO_EN
    assign io_hit = (bus.ram_addr_i == IO_ADDR);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gpio_o <= '0;
        end else if (in_run && bus.enram_i && bus.wrram_i && io_hit) begin
            gpio_o <= bus.ram_data_i;
        end
    end
`else
    logic unused_io_addr;
    assign unused_io_addr = ^IO_ADDR;
    assign io_hit         = 1'b0;
    assign gpio_o         = '0;
`endif

    assign dmem_we = in_run && bus.enram_i && bus.wrram_i && !io_hit;

    // Memory arrays carry no reset so their contents survive a CPU restart.
    always_ff @(posedge clk_i) begin
        if (rst_i && load_beat) begin
            imem[load_ptr] <= bus.load_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && dmem_we) begin
            dmem[ram_idx] <= bus.ram_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= ST_LOAD;
            load_ptr         <= '0;
            run_o            <= 1'b0;
            bus.load_ready_o <= 1'b1;
            bus.rom_data_o   <= '0;
            bus.ram_data_o   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_beat) begin
                        load_ptr <= load_ptr + 1'b1;
                        // Last-flagged beat or a full IMEM both end the load.
                        if (bus.load_last_i || (load_ptr == IA_W'(IMEM_DEPTH - 1))) begin
                            state            <= ST_RUN;
                            run_o            <= 1'b1;
                            bus.load_ready_o <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.enrom_i) begin
                        bus.rom_data_o <= imem[rom_idx];
                    end
                    if (bus.enram_i && !bus.wrram_i) begin
                        bus.ram_data_o <= io_hit ? gpio_o : dmem[ram_idx];
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule
